test_status_dev: RTL

//  Memory-mapped test-status responder on the RV64I data bus. The CPU stores its

---
 rtl/rv64_tsd_pkg.sv | 35 +++
 rtl/test_status_dev.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rv64_tsd_pkg.sv
// Shared definitions for the test-status responder: register offsets,
// STATUS bit positions, FSM state type and the byte-merge helper.
package rv64_tsd_pkg;

  localparam int unsigned TSD_WINDOW_BYTES = 32;

  localparam logic [4:0] TSD_OFF_TOHOST  = 5'h00;
  localparam logic [4:0] TSD_OFF_CYCLES  = 5'h08;
  localparam logic [4:0] TSD_OFF_SCRATCH = 5'h10;
  localparam logic [4:0] TSD_OFF_STATUS  = 5'h18;

  localparam int unsigned TSD_ST_DONE    = 0;
  localparam int unsigned TSD_ST_PASS    = 1;
  localparam int unsigned TSD_ST_FAIL    = 2;
  localparam int unsigned TSD_ST_TIMEOUT = 3;

  typedef enum logic [1:0] {
    TSD_RUN     = 2'd0,
    TSD_DONE    = 2'd1,
    TSD_TIMEOUT = 2'd2
  } tsd_state_e;

  // Replace the bytes of old_v selected by strb with the same bytes of new_v.
  function automatic logic [63:0] tsd_merge(input logic [63:0] old_v,
                                            input logic [63:0] new_v,
                                            input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/test_status_dev.sv
// Memory-mapped test-status responder: decodes the tohost result written by
// the CPU into pass/fail/timeout pins and freezes the run cycle count.
module test_status_dev
  import rv64_tsd_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR      = 64'h9000,
  parameter int unsigned TIMEOUT_CYCLES = 400000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [7:0]       req_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  tsd_state_e       state_q, state_d;
  logic [63:0]      tohost_q, tohost_d;
  logic [63:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [30:0]      fail_code_q, fail_code_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic        accept;
  logic [63:0] offset;
  logic [4:0]  reg_off;
  logic        addr_err;
  logic        wr_ok;
  logic        tohost_wr;
  logic [63:0] tohost_merged;
  logic        end_hit;
  logic        timeout_hit;
  logic [3:0]  status_vec;
  logic [63:0] rd_data;

  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;

  // Addresses below the base wrap to a huge offset, so one compare covers both edges.
  assign offset   = req_addr - BASE_ADDR;
  assign reg_off  = offset[4:0] & 5'b11000;
  assign addr_err = (offset >= 64'(TSD_WINDOW_BYTES)) | (req_addr[2:0] != 3'b000);

  assign wr_ok         = accept & req_we & ~addr_err;
  assign tohost_wr     = wr_ok & (reg_off == TSD_OFF_TOHOST) & (state_q == TSD_RUN);
  assign tohost_merged = tsd_merge(tohost_q, req_wdata, req_wstrb);
  assign end_hit       = tohost_wr & tohost_merged[0];
  // An ending store in the same cycle takes priority over the timeout.
  assign timeout_hit   = (state_q == TSD_RUN) & (cycles_q == CYC_LAST) & ~end_hit;

  always_comb begin
    status_vec                 = '0;
    status_vec[TSD_ST_DONE]    = done_q;
    status_vec[TSD_ST_PASS]    = pass_q;
    status_vec[TSD_ST_FAIL]    = fail_q;
    status_vec[TSD_ST_TIMEOUT] = timeout_q;
  end

  always_comb begin
    rd_data = '0;
    case (reg_off)
      TSD_OFF_TOHOST:  rd_data = tohost_q;
      TSD_OFF_CYCLES:  rd_data = 64'(cycles_q);
      TSD_OFF_SCRATCH: rd_data = scratch_q;
      TSD_OFF_STATUS:  rd_data = 64'(status_vec);
      default:         rd_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    if (end_hit) begin
      state_d = TSD_DONE;
      done_d  = 1'b1;
      if (tohost_merged[31:1] == 31'd0) begin
        pass_d = 1'b1;
      end else begin
        fail_d      = 1'b1;
        fail_code_d = tohost_merged[31:1];
      end
    end else if (timeout_hit) begin
      state_d   = TSD_TIMEOUT;
      done_d    = 1'b1;
      fail_d    = 1'b1;
      timeout_d = 1'b1;
    end
  end

  always_comb begin
    tohost_d  = tohost_wr ? tohost_merged : tohost_q;
    scratch_d = scratch_q;
    if (wr_ok && (reg_off == TSD_OFF_SCRATCH)) begin
      scratch_d = tsd_merge(scratch_q, req_wdata, req_wstrb);
    end
    cycles_d = cycles_q;
    if ((state_q == TSD_RUN) && (cycles_q != '1)) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
  end

  // Single-entry response stage: loaded on accept, cleared once consumed.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = addr_err;
      rsp_rdata_d = (req_we | addr_err) ? 64'd0 : rd_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= TSD_RUN;
      tohost_q    <= '0;
      scratch_q   <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tohost_q    <= tohost_d;
      scratch_q   <= scratch_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_code = fail_code_q;
  assign cycles    = cycles_q;

endmodule
